fifo_rd_sched: RTL and testbench
================================

FIFO_RD_SCHED -- requirements
Module: fifo_rd_sched

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- NREQ, 4, number of read requesters.
- DSIZE, 8, FIFO data width.
- BURST, 4, maximum words per grant (>=1).
- TIMEOUT, 16, stall-cycle limit (used only under FIFO_RD_SCHED_TIMEOUT_EN).
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- rclk, in, 1, read-domain clock; one clock, all logic on posedge.
- rrst, in, 1, reset; synchronous and active-high.
- req, in, NREQ, per-requester read request, level.
- rempty, in, 1, FIFO empty flag (read domain).
- rdata, in, DSIZE, FIFO read data; valid while rempty=0.
- rinc, out, 1, FIFO read-pointer increment (combinational from state).
- gnt, out, NREQ, one-hot grant; registered.
- dout, out, DSIZE, captured read word.
- dout_vld, out, 1, dout valid strobe, one cycle per word.
- dout_id, out, clog2(NREQ), requester index owning dout.

Function
REQ-003 FSM states SHALL be IDLE and READ only.
REQ-004 IDLE with req=0 SHALL stay in IDLE with gnt=0 and rinc=0.
REQ-005 IDLE with req!=0 SHALL pick one requester round-robin, searching from last_gid+1 upward with modulo-NREQ wrap, latch gid, set gnt one-hot, clear cnt, and enter READ next cycle.
REQ-006 In READ, rinc SHALL be 1 iff rempty=0 and req[gid]=1.
REQ-007 Each rinc cycle SHALL capture dout<=rdata and dout_id<=gid, and set dout_vld=1 on the next cycle (1-cycle latency); otherwise dout_vld=0.
REQ-008 cnt SHALL increment on each rinc and never exceed BURST-1.
REQ-009 READ SHALL exit to IDLE when (rinc and cnt==BURST-1) or req[gid]=0; on exit gnt<=0 and last_gid<=gid.
REQ-010 rempty=1 in READ with req[gid]=1 SHALL stall (rinc=0, cnt held, gnt held); the block never reads while rempty=1.
REQ-011 Requesters other than gid SHALL be ignored until return to IDLE; there is at least one IDLE cycle between bursts.
REQ-012 A requester deasserting req in the same cycle data becomes available SHALL receive no word that cycle (req has priority over rdata).
REQ-013 All-requesters-active SHALL yield grant order 0,1,2,3,0,... from reset.
REQ-014 dout SHALL hold its last value when dout_vld=0.

Reset
REQ-015 On rrst=1 at a rclk edge: state=IDLE, gnt=0, cnt=0, dout=0, dout_vld=0, dout_id=0, last_gid=NREQ-1 (so requester 0 wins first).
REQ-016 rinc SHALL be 0 during and on the cycle following reset.
REQ-017 Reset mid-burst SHALL abort the burst with no further rinc; partial burst is not resumed.

Configuration
REQ-018 Macro FIFO_RD_SCHED_TIMEOUT_EN: when defined, a stall counter SHALL count consecutive READ cycles with rempty=1, and on reaching TIMEOUT SHALL exit READ as in REQ-009 (last_gid<=gid).
REQ-019 Without FIFO_RD_SCHED_TIMEOUT_EN, no stall counter SHALL exist and REQ-010 stalls are unbounded.

Verification
REQ-020 req=4'b1111, FIFO holds 12 words, BURST=4 -> bursts to ids 0,1,2 of 4 words each, dout_id sequence 0x4,1x4,2x4, exactly 12 rinc.
REQ-021 req=4'b0100, FIFO holds 2 words -> 2 rinc, then rempty=1 stall with gnt=4'b0100 held; push 1 word -> 1 more rinc with dout_id=2.
REQ-022 req[1] drops after 2 words of a burst -> rinc stops same cycle, IDLE next, next grant goes to id 2 if req[2]=1.
REQ-023 rrst pulsed on 3rd word of a burst -> next cycle gnt=0, dout_vld=0, rinc=0; after release with req=4'b1111, first grant id 0.
REQ-024 With FIFO_RD_SCHED_TIMEOUT_EN, TIMEOUT=16, req=4'b0011, empty FIFO -> gnt=4'b0001 for 16 stall cycles, IDLE, then gnt=4'b0010.
REQ-025 Word values 0xA5,0x5A,0x3C pushed -> dout matches in order, each dout_vld exactly one cycle after its rinc.

Source files
------------

// File: rtl/fifo_rd_sched.sv
// fifo_rd_sched -- round-robin read scheduler sitting on the read side of a FIFO.
// One requester at a time owns the FIFO for a burst of up to BURST words.
// Each word read is presented on dout one cycle after its rinc, tagged with the owner id.
// Optional feature: define FIFO_RD_SCHED_TIMEOUT_EN to end a burst after TIMEOUT
// consecutive empty-FIFO cycles. Without it, empty-FIFO stalls last indefinitely.
module fifo_rd_sched #(
   parameter int NREQ    = 4,
   parameter int DSIZE   = 8,
   parameter int BURST   = 4,
   parameter int TIMEOUT = 16,
   localparam int IW     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic             rclk,
   input  logic             rrst,
   input  logic [NREQ-1:0]  req,
   input  logic             rempty,
   input  logic [DSIZE-1:0] rdata,
   output logic             rinc,
   output logic [NREQ-1:0]  gnt,
   output logic [DSIZE-1:0] dout,
   output logic             dout_vld,
   output logic [IW-1:0]    dout_id
);

   localparam int CW = (BURST > 1) ? $clog2(BURST) : 1;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_READ = 1'b1
   } state_t;

   // Reject configurations that have no meaningful behaviour
   if (NREQ < 1 || DSIZE < 1 || BURST < 1 || TIMEOUT < 1) begin : g_bad_cfg
      $error("fifo_rd_sched: NREQ, DSIZE, BURST and TIMEOUT must all be >= 1");
   end

   state_t            state_r;
   state_t            state_nxt_s;
   logic [IW-1:0]     gid_r;
   logic [IW-1:0]     last_gid_r;
   logic [CW-1:0]     cnt_r;
   logic [NREQ-1:0]   gnt_r;
   logic [DSIZE-1:0]  dout_r;
   logic              dout_vld_r;
   logic [IW-1:0]     dout_id_r;
   logic              pick_vld_s;
   logic [IW-1:0]     pick_id_s;
   logic              rinc_s;
   logic              exit_s;
   logic              last_beat_s;
   logic              timeout_hit_s;

   // Round-robin search starting just after the last owner; the nearest requester wins
   always_comb begin
      logic [IW-1:0] cand_v;
      cand_v     = {IW{1'b0}};
      pick_vld_s = 1'b0;
      pick_id_s  = {IW{1'b0}};
      for (int i = NREQ; i >= 1; i--) begin
         cand_v = IW'((int'(last_gid_r) + i) % NREQ);
         if (req[cand_v]) begin
            pick_vld_s = 1'b1;
            pick_id_s  = cand_v;
         end else begin
            pick_vld_s = pick_vld_s;
            pick_id_s  = pick_id_s;
         end
      end
   end

   assign last_beat_s = (cnt_r == CW'(BURST - 1));

   // Next-state logic and the read strobe; a dropped request beats available data
   always_comb begin
      state_nxt_s = state_r;
      rinc_s      = 1'b0;
      exit_s      = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (pick_vld_s) begin
               state_nxt_s = ST_READ;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_READ: begin
            rinc_s = ~rempty & req[gid_r] & ~rrst;
            exit_s = (rinc_s & last_beat_s) | ~req[gid_r] | timeout_hit_s;
            if (exit_s) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_READ;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // State register
   always_ff @(posedge rclk) begin
      if (rrst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Grant, current owner, last owner and beat count within the burst
   always_ff @(posedge rclk) begin
      if (rrst) begin
         gnt_r      <= {NREQ{1'b0}};
         gid_r      <= {IW{1'b0}};
         last_gid_r <= IW'(NREQ - 1);
         cnt_r      <= {CW{1'b0}};
      end else if (state_r == ST_IDLE && pick_vld_s) begin
         gnt_r <= NREQ'(1'b1) << pick_id_s;
         gid_r <= pick_id_s;
         cnt_r <= {CW{1'b0}};
      end else if (exit_s) begin
         gnt_r      <= {NREQ{1'b0}};
         last_gid_r <= gid_r;
         cnt_r      <= {CW{1'b0}};
      end else if (rinc_s) begin
         cnt_r <= cnt_r + CW'(1'b1);
      end else begin
         cnt_r <= cnt_r;
      end
   end

   // Capture each word read; dout keeps its value between strobes
   always_ff @(posedge rclk) begin
      if (rrst) begin
         dout_r     <= {DSIZE{1'b0}};
         dout_vld_r <= 1'b0;
         dout_id_r  <= {IW{1'b0}};
      end else if (rinc_s) begin
         dout_r     <= rdata;
         dout_vld_r <= 1'b1;
         dout_id_r  <= gid_r;
      end else begin
         dout_vld_r <= 1'b0;
      end
   end

`ifdef FIFO_RD_SCHED_TIMEOUT_EN
   localparam int SW = $clog2(TIMEOUT + 1);
   logic [SW-1:0] stall_cnt_r;

   // Count consecutive READ cycles spent waiting on an empty FIFO
   always_ff @(posedge rclk) begin
      if (rrst) begin
         stall_cnt_r <= {SW{1'b0}};
      end else if (state_r == ST_READ && rempty && !exit_s) begin
         stall_cnt_r <= stall_cnt_r + SW'(1'b1);
      end else begin
         stall_cnt_r <= {SW{1'b0}};
      end
   end

   assign timeout_hit_s = (state_r == ST_READ) & rempty & (stall_cnt_r == SW'(TIMEOUT - 1));
`else
   assign timeout_hit_s = 1'b0;
`endif

   assign rinc     = rinc_s;
   assign gnt      = gnt_r;
   assign dout     = dout_r;
   assign dout_vld = dout_vld_r;
   assign dout_id  = dout_id_r;

endmodule

// File: tb/tb_fifo_rd_sched.sv
// tb_fifo_rd_sched -- directed bench for fifo_rd_sched with a queue standing in for the FIFO.
// Covers FIFO_RD_SCHED_TIMEOUT_EN behaviour when that macro is defined, unbounded stall otherwise.
module tb_fifo_rd_sched;

   localparam int NREQ    = 4;
   localparam int DSIZE   = 8;
   localparam int BURST   = 4;
   localparam int TIMEOUT = 16;

   logic            rclk = 1'b0;
   logic            rrst;
   logic [3:0]      req;
   logic            rempty;
   logic [7:0]      rdata;
   logic            rinc;
   logic [3:0]      gnt;
   logic [7:0]      dout;
   logic            dout_vld;
   logic [1:0]      dout_id;

   int              n_cmp = 0;
   int              n_err = 0;
   logic [7:0]      fifo_q[$];
   logic [7:0]      pop_v;
   int              obs_id[$];
   int              obs_dat[$];
   int              obs_gnt[$];
   int              exp_id[$];
   int              exp_dat[$];
   int              exp_gnt[$];
   int              rinc_cnt;
   logic [3:0]      gnt_last;
   logic            rinc_pre;
   logic            rempty_pre;
   int              n_gnt0;

   fifo_rd_sched #(
      .NREQ    (NREQ),
      .DSIZE   (DSIZE),
      .BURST   (BURST),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .rclk     (rclk),
      .rrst     (rrst),
      .req      (req),
      .rempty   (rempty),
      .rdata    (rdata),
      .rinc     (rinc),
      .gnt      (gnt),
      .dout     (dout),
      .dout_vld (dout_vld),
      .dout_id  (dout_id)
   );

   // Free-running read clock
   always #5 rclk = ~rclk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic fifo_upd();
      rempty = (fifo_q.size() == 0);
      rdata  = (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;
   endtask

   task automatic push(input logic [7:0] v);
      fifo_q.push_back(v);
      fifo_upd();
   endtask

   task automatic clear_logs();
      obs_id.delete();
      obs_dat.delete();
      obs_gnt.delete();
      exp_id.delete();
      exp_dat.delete();
      exp_gnt.delete();
      rinc_cnt = 0;
   endtask

   // One clock: sample rinc before the edge, outputs 1 time unit after it
   task automatic cyc();
      #2;
      rinc_pre   = rinc;
      rempty_pre = rempty;
      @(posedge rclk);
      #1;
      if (rinc_pre === 1'b1) begin
         rinc_cnt++;
         if (fifo_q.size() > 0) begin
            pop_v = fifo_q.pop_front();
         end
      end
      check_eq("read_while_empty", 32'(rinc_pre & rempty_pre), 32'd0);
      check_eq("vld_latency", 32'(dout_vld), 32'(rinc_pre));
      if (dout_vld === 1'b1) begin
         obs_id.push_back(int'(dout_id));
         obs_dat.push_back(int'(dout));
      end
      if (gnt != 4'b0000 && gnt_last == 4'b0000) begin
         obs_gnt.push_back(int'(gnt));
      end
      gnt_last = gnt;
      fifo_upd();
   endtask

   task automatic compare_logs(input string tag);
      check_eq({tag, "_rinc_cnt"}, 32'(rinc_cnt), 32'(exp_dat.size()));
      check_eq({tag, "_nwords"}, 32'(obs_id.size()), 32'(exp_id.size()));
      for (int i = 0; i < exp_id.size(); i++) begin
         if (i < obs_id.size()) begin
            check_eq($sformatf("%s_id%0d", tag, i), 32'(obs_id[i]), 32'(exp_id[i]));
            check_eq($sformatf("%s_dat%0d", tag, i), 32'(obs_dat[i]), 32'(exp_dat[i]));
         end
      end
      check_eq({tag, "_ngrants"}, 32'(obs_gnt.size()), 32'(exp_gnt.size()));
      for (int i = 0; i < exp_gnt.size(); i++) begin
         if (i < obs_gnt.size()) begin
            check_eq($sformatf("%s_gnt%0d", tag, i), 32'(obs_gnt[i]), 32'(exp_gnt[i]));
         end
      end
   endtask

   initial begin
      rrst     = 1'b1;
      req      = 4'b0000;
      gnt_last = 4'b0000;
      rinc_cnt = 0;
      fifo_upd();

      // Reset state
      cyc();
      cyc();
      check_eq("rst_rinc", 32'(rinc_pre), 32'd0);
      check_eq("rst_gnt", 32'(gnt), 32'd0);
      check_eq("rst_dout", 32'(dout), 32'd0);
      check_eq("rst_vld", 32'(dout_vld), 32'd0);
      check_eq("rst_id", 32'(dout_id), 32'd0);
      rrst = 1'b0;
      cyc();
      check_eq("post_rst_rinc", 32'(rinc_pre), 32'd0);
      check_eq("idle_gnt", 32'(gnt), 32'd0);

      // All requesters, 12 words: three full bursts to 0,1,2 then 3 stalls on empty
      clear_logs();
      for (int i = 0; i < 12; i++) push(8'h10 + 8'(i));
      req = 4'b1111;
      repeat (30) cyc();
      check_eq("rr_stall_gnt", 32'(gnt), 32'h8);
      exp_id  = '{0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2};
      for (int i = 0; i < 12; i++) exp_dat.push_back(16 + i);
      exp_gnt = '{1, 2, 4, 8};
      compare_logs("rr");
      req = 4'b0000;
      cyc();
      cyc();
      check_eq("rr_release_gnt", 32'(gnt), 32'd0);

      // Requester 2 alone: two words, stall with grant held, one more word after push
      clear_logs();
      push(8'hA5);
      push(8'h5A);
      req = 4'b0100;
      repeat (10) cyc();
      check_eq("stall_gnt", 32'(gnt), 32'h4);
      check_eq("stall_rinc", 32'(rinc), 32'd0);
      check_eq("stall_cnt2", 32'(rinc_cnt), 32'd2);
      push(8'h3C);
      repeat (3) cyc();
      exp_id  = '{2, 2, 2};
      exp_dat = '{'hA5, 'h5A, 'h3C};
      exp_gnt = '{4};
      compare_logs("stall");
      req = 4'b0000;
      cyc();
      cyc();
      check_eq("hold_dout", 32'(dout), 32'h3C);
      check_eq("hold_vld", 32'(dout_vld), 32'd0);

      // Requester 1 drops after two words while data is still available; 2 takes over
      clear_logs();
      for (int i = 0; i < 6; i++) push(8'h20 + 8'(i));
      req = 4'b0110;
      repeat (3) cyc();
      req = 4'b0100;
      cyc();
      check_eq("drop_no_rd", 32'(rinc_pre), 32'd0);
      check_eq("drop_idle_gnt", 32'(gnt), 32'd0);
      repeat (5) cyc();
      req = 4'b0000;
      cyc();
      cyc();
      exp_id  = '{1, 1, 2, 2, 2, 2};
      exp_dat = '{'h20, 'h21, 'h22, 'h23, 'h24, 'h25};
      exp_gnt = '{2, 4};
      compare_logs("drop");

      // Reset on the third word of a burst to requester 3; restart grants 0 first
      clear_logs();
      for (int i = 0; i < 8; i++) push(8'h30 + 8'(i));
      req = 4'b1111;
      repeat (3) cyc();
      rrst = 1'b1;
      cyc();
      check_eq("midrst_rinc_pre", 32'(rinc_pre), 32'd0);
      check_eq("midrst_gnt", 32'(gnt), 32'd0);
      check_eq("midrst_vld", 32'(dout_vld), 32'd0);
      check_eq("midrst_rinc", 32'(rinc), 32'd0);
      rrst = 1'b0;
      cyc();
      check_eq("after_rst_rinc", 32'(rinc_pre), 32'd0);
      check_eq("after_rst_gnt", 32'(gnt), 32'h1);
      repeat (4) cyc();
      req = 4'b0000;
      cyc();
      exp_id  = '{3, 3, 0, 0, 0, 0};
      exp_dat = '{'h30, 'h31, 'h32, 'h33, 'h34, 'h35};
      exp_gnt = '{8, 1};
      compare_logs("midrst");
      check_eq("midrst_last_id", 32'(dout_id), 32'd0);
      fifo_q.delete();
      fifo_upd();
      cyc();

      // Empty FIFO with requesters 0 and 1 from a fresh reset
      rrst = 1'b1;
      cyc();
      rrst = 1'b0;
      clear_logs();
      req    = 4'b0011;
      n_gnt0 = 0;
`ifdef FIFO_RD_SCHED_TIMEOUT_EN
      repeat (17) begin
         cyc();
         if (gnt == 4'b0001) n_gnt0++;
      end
      check_eq("to_gnt0_cycles", 32'(n_gnt0), 32'd16);
      check_eq("to_idle_gnt", 32'(gnt), 32'd0);
      cyc();
      check_eq("to_next_gnt", 32'(gnt), 32'h2);
`else
      repeat (40) begin
         cyc();
         if (gnt == 4'b0001) n_gnt0++;
      end
      check_eq("nto_gnt0_cycles", 32'(n_gnt0), 32'd40);
      check_eq("nto_gnt", 32'(gnt), 32'h1);
`endif
      check_eq("empty_rinc_cnt", 32'(rinc_cnt), 32'd0);
      req = 4'b0000;
      cyc();
      cyc();
      check_eq("final_gnt", 32'(gnt), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
